// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: access size codes, FSM states
// and the default ack watchdog limit.
package load_store_unit_pkg;

  localparam logic [1:0] MEM_BYTE = 2'b00;
  localparam logic [1:0] MEM_HALF = 2'b01;
  localparam logic [1:0] MEM_WORD = 2'b10;

  localparam int DEFAULT_TIMEOUT = 255;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'b00,
    LSU_REQ  = 2'b01,
    LSU_DONE = 2'b10
  } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane logic: store byte enables and data replication,
// load lane extraction with sign/zero extension, and alignment checking.
module lsu_align
  import load_store_unit_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic        ext_sign,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_value,
  output logic        misaligned
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = rdata[7:0];
    case (addr_lo)
      2'd1:    byte_lane = rdata[15:8];
      2'd2:    byte_lane = rdata[23:16];
      2'd3:    byte_lane = rdata[31:24];
      default: byte_lane = rdata[7:0];
    endcase
    half_lane = addr_lo[1] ? rdata[31:16] : rdata[15:0];
  end

  // The reserved size code behaves exactly like a word access.
  always_comb begin
    be         = 4'b1111;
    wdata      = store_data;
    load_value = rdata;
    misaligned = 1'b0;
    case (size)
      MEM_BYTE: begin
        be         = 4'b0001 << addr_lo;
        wdata      = {4{store_data[7:0]}};
        load_value = {{24{ext_sign & byte_lane[7]}}, byte_lane};
      end
      MEM_HALF: begin
        be         = 4'b0011 << addr_lo;
        wdata      = {2{store_data[15:0]}};
        load_value = {{16{ext_sign & half_lane[15]}}, half_lane};
        misaligned = addr_lo[0];
      end
      MEM_WORD, 2'b11: begin
        misaligned = (addr_lo != 2'b00);
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory interface stage: req/ack handshake with core stall, lane steering.
// Define LSU_TIMEOUT_EN to enable the ack watchdog (TIMEOUT_CYCLES) and bus_err.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  mem_size,
  input  logic        ext_sign,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic [31:0] load_data,
  output logic        stall,
  output logic        misaligned,
  output logic        bus_err,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack
);

  lsu_state_e  state, state_nxt;
  logic [1:0]  lat_size, lat_addr_lo;
  logic        lat_sign;
  logic [1:0]  sel_size, sel_addr_lo;
  logic        sel_sign;
  logic [3:0]  al_be;
  logic [31:0] al_wdata, al_load;
  logic        al_misaligned;
  logic        op, start, reject, complete, abort;

  // While idle the aligner looks at the live op; afterwards at the latched one.
  always_comb begin
    sel_size    = lat_size;
    sel_addr_lo = lat_addr_lo;
    sel_sign    = lat_sign;
    if (state == LSU_IDLE) begin
      sel_size    = mem_size;
      sel_addr_lo = addr[1:0];
      sel_sign    = ext_sign;
    end
  end

  lsu_align u_align (
    .size       (sel_size),
    .addr_lo    (sel_addr_lo),
    .ext_sign   (sel_sign),
    .store_data (store_data),
    .rdata      (dmem_rdata),
    .be         (al_be),
    .wdata      (al_wdata),
    .load_value (al_load),
    .misaligned (al_misaligned)
  );

  assign op       = mem_read | mem_write;
  assign start    = (state == LSU_IDLE) && op && !al_misaligned;
  assign reject   = (state == LSU_IDLE) && op && al_misaligned;
  assign complete = (state == LSU_REQ) && dmem_ack;

`ifdef LSU_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CNT_W-1:0] req_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_cnt <= '0;
    end else if (start) begin
      req_cnt <= '0;
    end else if ((state == LSU_REQ) && !dmem_ack) begin
      req_cnt <= req_cnt + CNT_W'(1);
    end
  end

  // An ack on the final allowed cycle wins over the abort.
  assign abort = (state == LSU_REQ) && !dmem_ack && (req_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign abort          = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= LSU_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    case (state)
      LSU_IDLE: begin
        if (start) begin
          stall     = 1'b1;
          state_nxt = LSU_REQ;
        end
      end
      LSU_REQ: begin
        stall = 1'b1;
        if (complete || abort) state_nxt = LSU_DONE;
      end
      LSU_DONE: state_nxt = LSU_IDLE;
      default:  state_nxt = LSU_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dmem_req    <= 1'b0;
      dmem_we     <= 1'b0;
      dmem_addr   <= '0;
      dmem_be     <= '0;
      dmem_wdata  <= '0;
      lat_size    <= MEM_BYTE;
      lat_addr_lo <= 2'b00;
      lat_sign    <= 1'b0;
      load_data   <= '0;
      misaligned  <= 1'b0;
      bus_err     <= 1'b0;
    end else begin
      misaligned <= reject;
      bus_err    <= abort;
      if (start) begin
        dmem_req    <= 1'b1;
        dmem_we     <= mem_write;
        dmem_addr   <= {addr[31:2], 2'b00};
        dmem_be     <= al_be;
        dmem_wdata  <= al_wdata;
        lat_size    <= mem_size;
        lat_addr_lo <= addr[1:0];
        lat_sign    <= ext_sign;
      end else if (complete || abort) begin
        dmem_req <= 1'b0;
      end
      if (reject || abort) begin
        load_data <= '0;
      end else if (complete && !dmem_we) begin
        load_data <= al_load;
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: directed loads/stores against a
// simple acking memory; a negedge monitor checks requests, retirements, pulses.
module tb_load_store_unit;

  localparam int EV_REQ  = 0;
  localparam int EV_DONE = 1;
  localparam int EV_MIS  = 2;

  typedef struct {
    int          kind;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic [31:0] d;
  } evT;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read, mem_write, ext_sign;
  logic [1:0]  mem_size;
  logic [31:0] addr, store_data;
  logic [31:0] load_data;
  logic        stall, misaligned, bus_err;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;

  evT          expq[$];
  int          vecCount = 0;
  int          missCount = 0;
  logic [31:0] memRdata = '0;
  int          ackDelay = 0;
  int          reqCycles = 0;
  bit          ackDone = 0;
  bit          prevReq = 0;
  bit          prevStall = 0;
  int          stallRun = 0;

  load_store_unit #(.TIMEOUT_CYCLES(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_size   (mem_size),
    .ext_sign   (ext_sign),
    .addr       (addr),
    .store_data (store_data),
    .load_data  (load_data),
    .stall      (stall),
    .misaligned (misaligned),
    .bus_err    (bus_err),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_be    (dmem_be),
    .dmem_wdata (dmem_wdata),
    .dmem_rdata (dmem_rdata),
    .dmem_ack   (dmem_ack)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vecCount++;
    if (actual !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic popExpect(input int kind, output evT e, output bit ok);
    e.kind = -1; e.a = '0; e.b = '0; e.c = '0; e.d = '0;
    ok = 1'b0;
    if (expq.size() == 0) begin
      vecCount++;
      missCount++;
      $display("[TB] FAIL event_queue: observed event kind %0d with nothing queued", kind);
    end else begin
      e = expq.pop_front();
      checkOutput("event_kind", kind, e.kind);
      ok = (kind == e.kind);
    end
  endtask

  // Memory responder: acks after ackDelay request cycles, garbage data otherwise.
  always @(posedge clk) begin
    #1;
    dmem_ack   = 1'b0;
    dmem_rdata = ~memRdata;
    if (!dmem_req) begin
      reqCycles = 0;
      ackDone   = 0;
    end else if (!ackDone) begin
      if (reqCycles == ackDelay) begin
        dmem_ack   = 1'b1;
        dmem_rdata = memRdata;
        ackDone    = 1;
      end
      reqCycles++;
    end
  end

  // Monitor: compares each observable DUT event with the scoreboard head.
  always @(negedge clk) begin
    evT e;
    bit ok;
    if (rst) begin
      prevReq   = 0;
      prevStall = 0;
      stallRun  = 0;
    end else begin
      if (dmem_req && !prevReq) begin
        popExpect(EV_REQ, e, ok);
        if (ok) begin
          checkOutput("req_we", {31'd0, dmem_we}, e.a);
          checkOutput("req_addr", dmem_addr, e.b);
          checkOutput("req_be", {28'd0, dmem_be}, e.c);
          checkOutput("req_wdata", dmem_wdata, e.d);
        end
      end
      if (misaligned) begin
        popExpect(EV_MIS, e, ok);
        if (ok) begin
          checkOutput("mis_load_data", load_data, e.a);
          checkOutput("mis_prev_stall", {31'd0, prevStall}, e.b);
          checkOutput("mis_req", {31'd0, dmem_req}, e.c);
        end
      end
      if (stall) begin
        stallRun++;
      end else if (prevStall) begin
        popExpect(EV_DONE, e, ok);
        if (ok) begin
          checkOutput("done_load_data", load_data, e.a);
          checkOutput("done_stall_cycles", stallRun, e.b);
          checkOutput("done_bus_err", {31'd0, bus_err}, e.c);
        end
        stallRun = 0;
      end else if (bus_err) begin
        checkOutput("stray_bus_err", {31'd0, bus_err}, 32'd0);
      end
      prevReq   = dmem_req;
      prevStall = stall;
    end
  end

  task automatic applyStimulus(input logic rd, input logic wr, input logic [1:0] sz, input logic sg,
                               input logic [31:0] a, input logic [31:0] sd, input logic [31:0] rdat,
                               input int dly, input logic expMis, input logic [3:0] expBe,
                               input logic [31:0] expWdata, input logic [31:0] expLoad,
                               input int expStall, input logic expBusErr);
    evT e;
    memRdata = rdat;
    ackDelay = dly;
    if (expMis) begin
      e.kind = EV_MIS; e.a = expLoad; e.b = '0; e.c = '0; e.d = '0;
      expq.push_back(e);
    end else begin
      e.kind = EV_REQ; e.a = {31'd0, wr}; e.b = {a[31:2], 2'b00}; e.c = {28'd0, expBe}; e.d = expWdata;
      expq.push_back(e);
      e.kind = EV_DONE; e.a = expLoad; e.b = expStall; e.c = {31'd0, expBusErr}; e.d = '0;
      expq.push_back(e);
    end
    @(posedge clk); #1;
    mem_read = rd; mem_write = wr; mem_size = sz; ext_sign = sg; addr = a; store_data = sd;
    @(posedge clk); #1;
    mem_read = 1'b0; mem_write = 1'b0; mem_size = 2'b00; ext_sign = ~sg;
    addr = 32'hFFFF_FFFF; store_data = 32'h5A5A_5A5A;
    for (int i = 0; i < 300 && stall; i++) begin
      @(posedge clk); #1;
    end
    if (stall) begin
      vecCount++;
      missCount++;
      $display("[TB] FAIL stall_release: stall still 1 after 300 cycles, expected 0");
    end
    @(posedge clk); #1;
  endtask

  initial begin
    evT e;
    rst = 1'b1;
    mem_read = 1'b0; mem_write = 1'b0; mem_size = 2'b00; ext_sign = 1'b0;
    addr = '0; store_data = '0; dmem_ack = 1'b0; dmem_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_req", {31'd0, dmem_req}, 32'd0);
    checkOutput("rst_we", {31'd0, dmem_we}, 32'd0);
    checkOutput("rst_be", {28'd0, dmem_be}, 32'd0);
    checkOutput("rst_addr", dmem_addr, 32'd0);
    checkOutput("rst_wdata", dmem_wdata, 32'd0);
    checkOutput("rst_load_data", load_data, 32'd0);
    checkOutput("rst_misaligned", {31'd0, misaligned}, 32'd0);
    checkOutput("rst_bus_err", {31'd0, bus_err}, 32'd0);
    checkOutput("rst_stall", {31'd0, stall}, 32'd0);
    rst = 1'b0;

    //             rd wr size   sg addr          sdata         rdata         dly mis be     wdata         load          stl berr
    applyStimulus(0, 1, 2'b10, 0, 32'h0000_0104, 32'hDEAD_BEEF, 32'h0,        2, 0, 4'hF, 32'hDEAD_BEEF, 32'h0000_0000, 4, 0);
    applyStimulus(1, 0, 2'b00, 1, 32'h0000_0203, 32'h0,         32'h8011_2233, 0, 0, 4'h8, 32'h0,         32'hFFFF_FF80, 2, 0);
    applyStimulus(1, 0, 2'b00, 0, 32'h0000_0203, 32'h0,         32'h8011_2233, 1, 0, 4'h8, 32'h0,         32'h0000_0080, 3, 0);
    applyStimulus(0, 1, 2'b01, 0, 32'h0000_0302, 32'h0000_ABCD, 32'h0,        0, 0, 4'hC, 32'hABCD_ABCD, 32'h0000_0080, 2, 0);
    applyStimulus(1, 0, 2'b01, 0, 32'h0000_0302, 32'h0,         32'hABCD_0000, 1, 0, 4'hC, 32'h0,         32'h0000_ABCD, 3, 0);
    applyStimulus(1, 0, 2'b01, 1, 32'h0000_0102, 32'h0,         32'h8001_7FFF, 0, 0, 4'hC, 32'h0,         32'hFFFF_8001, 2, 0);
    applyStimulus(1, 0, 2'b00, 1, 32'h0000_0100, 32'h0,         32'hAABB_CC7F, 3, 0, 4'h1, 32'h0,         32'h0000_007F, 5, 0);
    applyStimulus(0, 1, 2'b00, 0, 32'h0000_0101, 32'h1234_56A5, 32'h0,        0, 0, 4'h2, 32'hA5A5_A5A5, 32'h0000_007F, 2, 0);
    applyStimulus(1, 1, 2'b10, 0, 32'h0000_0500, 32'h1122_3344, 32'h0,        1, 0, 4'hF, 32'h1122_3344, 32'h0000_007F, 3, 0);
    applyStimulus(1, 0, 2'b11, 1, 32'h0000_0600, 32'h0,         32'hCAFE_F00D, 0, 0, 4'hF, 32'h0,         32'hCAFE_F00D, 2, 0);
    applyStimulus(1, 0, 2'b00, 0, 32'h0000_0202, 32'h0,         32'h00FE_0000, 0, 0, 4'h4, 32'h0,         32'h0000_00FE, 2, 0);
    applyStimulus(1, 0, 2'b10, 0, 32'h0000_0401, 32'h0,         32'h0,        0, 1, 4'h0, 32'h0,         32'h0000_0000, 0, 0);
    applyStimulus(0, 1, 2'b01, 0, 32'h0000_0001, 32'h0000_1234, 32'h0,        0, 1, 4'h0, 32'h0,         32'h0000_0000, 0, 0);
    applyStimulus(1, 0, 2'b00, 0, 32'h0000_0201, 32'h0,         32'h0000_AB00, 2, 0, 4'h2, 32'h0,         32'h0000_00AB, 4, 0);

    // Reset while the request is outstanding: request withdrawn at once.
    e.kind = EV_REQ; e.a = 32'd0; e.b = 32'h0000_0680; e.c = 32'h0000_000F; e.d = 32'd0;
    expq.push_back(e);
    memRdata = 32'h1111_1111;
    ackDelay = 20;
    @(posedge clk); #1;
    mem_read = 1'b1; mem_size = 2'b10; ext_sign = 1'b0; addr = 32'h0000_0680; store_data = '0;
    @(posedge clk); #1;
    mem_read = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    checkOutput("rst_mid_req", {31'd0, dmem_req}, 32'd0);
    checkOutput("rst_mid_stall", {31'd0, stall}, 32'd0);
    checkOutput("rst_mid_load_data", load_data, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    applyStimulus(1, 0, 2'b01, 1, 32'h0000_0003, 32'h0,         32'h0,        0, 1, 4'h0, 32'h0,         32'h0000_0000, 0, 0);
    applyStimulus(1, 0, 2'b11, 0, 32'h0000_0602, 32'h0,         32'h0,        0, 1, 4'h0, 32'h0,         32'h0000_0000, 0, 0);
    applyStimulus(1, 0, 2'b10, 0, 32'h0000_0700, 32'h0,         32'h0123_4567, 3, 0, 4'hF, 32'h0,         32'h0123_4567, 5, 0);
`ifdef LSU_TIMEOUT_EN
    applyStimulus(1, 0, 2'b10, 0, 32'h0000_0800, 32'h0,         32'h9999_9999, 100, 0, 4'hF, 32'h0,       32'h0000_0000, 9, 1);
    applyStimulus(1, 0, 2'b10, 0, 32'h0000_0804, 32'h0,         32'h89AB_CDEF, 7, 0, 4'hF, 32'h0,         32'h89AB_CDEF, 9, 0);
`endif

    repeat (5) @(posedge clk);
    #1;
    checkOutput("queue_drained", expq.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Data-memory interface stage directly downstream of the control unit and ALU in the RISC-V core.
- Consumes the control unit's memory controls (MemSize, MemWrite, ExtSign, load enable) and the ALU address.
- Runs a req/ack handshake to data memory and stalls the core until the access completes.
- Performs byte-lane steering and store-data replication for stores, and extraction plus sign/zero extension for loads.

Parameters:
- TIMEOUT_CYCLES, 255: ack watchdog limit in cycles; used only when LSU_TIMEOUT_EN is defined.

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous, active-high reset.
- mem_read  in  1  load op this cycle (ResultSrc==2'b01 and not MemWrite).
- mem_write  in  1  store op this cycle (MemWrite).
- mem_size  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as word).
- ext_sign  in  1  1 = sign-extend load, 0 = zero-extend.
- addr  in  32  effective address from ALU.
- store_data  in  32  rs2 value.
- load_data  out  32  extended load result to the writeback mux.
- stall  out  1  freeze PC/regfile write while high.
- misaligned  out  1  one-cycle pulse on misaligned access.
- bus_err  out  1  one-cycle pulse on watchdog abort.
- dmem_req  out  1  request valid (registered).
- dmem_we  out  1  write strobe.
- dmem_addr  out  32  word-aligned address {addr[31:2],2'b00}.
- dmem_be  out  4  byte enables.
- dmem_wdata  out  32  lane-replicated store data.
- dmem_rdata  in  32  read data, valid with ack.
- dmem_ack  in  1  access complete.

Behaviour:
- Reset (async, rst=1): state IDLE; dmem_req/dmem_we/dmem_be/dmem_addr/dmem_wdata=0; load_data=0; misaligned=0; bus_err=0. stall=0.
- States are IDLE, REQ and DONE.
- IDLE:
  - op = mem_read|mem_write. If op and aligned: stall=1 combinationally, latch addr/size/ext_sign/we/wdata/be, go to REQ.
  - If mem_read and mem_write are both high, the write wins.
  - If op and misaligned (half with addr[0]=1; word/reserved with addr[1:0]!=0): no request, stall=0, misaligned=1 next cycle for 1 cycle, load_data=0, stay IDLE.
- REQ:
  - dmem_req=1, stall=1. Latched fields are held stable; input changes are ignored.
  - On dmem_ack: capture extracted rdata into load_data (loads only; stores leave load_data unchanged), dmem_req=0 next cycle, go to DONE.
  - Ack in the same cycle req first rises is legal.
- DONE: stall=0 so the instruction retires. Unconditionally go to IDLE next cycle; inputs are not sampled in DONE.
- Latency: best case 3 cycles from op presented to stall release (IDLE->REQ, ack, DONE).
- dmem_ack outside REQ is ignored.
- Byte enables:
  - byte: 4'b0001<<addr[1:0].
  - half: 4'b0011<<addr[1:0].
  - word: 4'b1111.
- Store data replication:
  - byte: {4{store_data[7:0]}}.
  - half: {2{store_data[15:0]}}.
  - word: as-is.
- Load extraction:
  - byte = rdata[8*addr[1:0]+:8].
  - half = rdata[16*addr[1]+:16].
  - Extension to 32 bits follows the latched ext_sign.
- Reset asserted mid-REQ: dmem_req drops immediately (async) and the transaction is abandoned. Memory must tolerate a withdrawn request.

Optional Feature:
- LSU_TIMEOUT_EN defined:
  - An 8-bit+ counter clears on entry to REQ and increments each REQ cycle without ack.
  - When it reaches TIMEOUT_CYCLES: dmem_req=0, bus_err pulses 1 cycle, load_data=0, go to DONE.
  - An ack arriving on the timeout cycle takes precedence over the abort.
- Undefined: no counter; REQ waits indefinitely; bus_err tied 0.

Decomposition:
- constants.vh gains:
  - MEM_BYTE/MEM_HALF/MEM_WORD size codes (2'b00/01/10).
  - LSU_IDLE/LSU_REQ/LSU_DONE state encodings.
  - Default TIMEOUT value.
- Sub-module lsu_align (combinational): takes size, addr[1:0], ext_sign, store_data, rdata; produces be, wdata, extracted load value, misaligned.

Test Plan:
- sw addr=0x104 data=0xDEADBEEF, ack after 2 cycles -> dmem_addr=0x104, be=1111, wdata=0xDEADBEEF, we=1, stall high 4 cycles then low.
- lb addr=0x203, ext_sign=1, rdata=0x80112233 -> be=1000, load_data=0xFFFFFF80. Repeat lbu -> 0x00000080.
- sh addr=0x302 data=0x0000ABCD -> be=1100, wdata=0xABCDABCD. lhu same addr, rdata=0xABCD0000 -> load_data=0x0000ABCD.
- lw addr=0x401 -> no dmem_req, misaligned pulse 1 cycle, stall never asserted. sh addr=0x1 -> same.
- rst asserted in REQ -> dmem_req=0 in the same cycle, state IDLE, stall=0. Next lw completes normally.
- With LSU_TIMEOUT_EN and TIMEOUT_CYCLES=8, no ack -> bus_err pulse after 8 REQ cycles, stall releases, load_data=0. Ack on cycle 8 -> data captured, no bus_err.
